x2050wait: RTL and testbench
============================

Name: x2050wait

Overview:
- Wait-state and interrupt-priority sequencer for the 2050.
- Sits directly downstream of the PSW<12:15> (A,M,W,P) register.
- Consumes the W and M bits together with the PSW system mask and the pending interrupt lines. Holds ROS advance while the CPU is in wait state.
- On an enabled interrupt, releases ROS and presents a latched, prioritized interrupt request to microcode until acknowledged.

Parameters:
- WAIT_SS, 6'd57: ROS special-function (SS) code that tests W and enters wait state.
- CNT_W, 16: width of the wait-cycle counter.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_ros_advance  input  1  ROS word advancing this cycle.
- i_ss  input  6  current ROS SS field.
- i_amwp  input  4  PSW<12:15>: [3]=A, [2]=M, [1]=W, [0]=P.
- i_sysmask  input  8  PSW<0:7>: [7-n] enables channel n for n=0..6; [0] enables external.
- i_io_req  input  7  pending I/O interrupt, bit n = channel n.
- i_ext_req  input  1  pending external interrupt.
- i_mck_req  input  1  pending machine check.
- i_int_ack  input  1  microcode has taken the interrupt (one-cycle pulse).
- o_wait  output  1  wait-state indicator (wait light).
- o_hold_ros  output  1  freeze ROS advance.
- o_int_req  output  1  interrupt pending to microcode.
- o_int_class  output  2  00 none, 01 machine check, 10 external, 11 I/O.
- o_int_chan  output  3  channel number when class=11, else 0.
- o_wait_cnt  output  CNT_W  cycles spent in the most recent wait.

Behaviour:
- All state is on posedge i_clk or posedge i_reset.
- Reset sets state=RUN and drives every output to 0, including o_wait_cnt.
- Reset mid-wait or mid-pending aborts the operation immediately; no request survives reset.

States:
- RUN
- WAIT
- PEND

RUN:
- o_wait=0, o_hold_ros=0, o_int_req=0.
- If i_ros_advance & i_ss==WAIT_SS & i_amwp[1]==1: go to WAIT next cycle and clear o_wait_cnt.
- If the W bit is 0, or i_ros_advance=0, stay in RUN.
- i_int_ack is ignored.

WAIT:
- o_wait=1, o_hold_ros=1.
- o_wait_cnt increments by 1 each WAIT cycle and saturates at all-ones (no wrap).
- Every cycle, resolve enabled requests by fixed priority:
  - machine check: i_mck_req & i_amwp[2];
  - then external: i_ext_req & i_sysmask[0];
  - then I/O: lowest n with i_io_req[n] & i_sysmask[7-n].
- If any request is enabled, latch class/chan and go to PEND next cycle.
- Masked requests never wake the CPU; the wait continues indefinitely.
- i_ros_advance, i_ss and i_int_ack are ignored.
- The W bit cannot change while ROS is held.

PEND:
- o_int_req=1, o_hold_ros=0, o_wait=1.
- Class/chan stay frozen; later changes on request or mask lines are ignored.
- On i_int_ack: go to RUN, clearing o_int_req, o_wait, o_int_class and o_int_chan.
- o_wait_cnt retains its final value until the next WAIT entry.

Latency:
- WAIT_SS with W=1 makes o_hold_ros high 1 cycle later.
- An enabled request sampled in WAIT makes o_int_req high 1 cycle later.
- An ack makes o_int_req low 1 cycle later.

Boundary conditions:
- Simultaneous machine check, external and I/O requests: class 01 wins.
- Several I/O channels pending: lowest channel number wins.
- A request already pending and enabled at WAIT entry is taken on the first WAIT cycle, giving o_wait_cnt=1.
- Ack arriving in the same cycle a request is latched is ignored; ack is only honoured in PEND.

Test Plan:
1. Reset wait: i_amwp=4'b0010, ss=57 with advance, no requests for 70000 cycles -> o_hold_ros=1, o_wait=1, o_wait_cnt saturates at 16'hFFFF. Then assert i_reset mid-wait -> all outputs 0 asynchronously, state RUN.
2. W=0 and ss=57 with advance -> stays RUN, o_hold_ros=0. Repeat with W=1 but i_ros_advance=0 -> stays RUN.
3. WAIT entry, then i_io_req=7'b0101000, i_sysmask=8'hFF after 5 cycles -> o_int_req=1 one cycle later, class=11, chan=3, o_wait_cnt=6.
4. In WAIT, i_mck_req=1 with M=0, plus i_ext_req=1 with mask[0]=1 -> class=10 (machine check masked). Repeat with M=1 -> class=01.
5. In WAIT, i_io_req=7'h7F with i_sysmask=8'h00 for 100 cycles -> no wake. Set mask[1] (channel 6) -> chan=6.
6. In PEND, change requests and masks -> class/chan unchanged. Pulse i_int_ack -> next cycle o_int_req=0, o_wait=0, class=00, o_wait_cnt held.

Source files
------------

// File: rtl/x2050wait.sv
// ---------------------------------------------------------------------------
// x2050wait -- wait-state and interrupt-priority sequencer for the 2050.
//
// Sits downstream of the PSW<12:15> (A,M,W,P) register. While the CPU is in
// wait state, ROS advance is frozen. The first enabled interrupt releases ROS
// and is presented to microcode as a latched, prioritized request until
// microcode acknowledges it.
//
// Ports:
//   i_clk          system clock
//   i_reset        asynchronous, active-high reset
//   i_ros_advance  ROS word advancing this cycle
//   i_ss           current ROS SS field
//   i_amwp         PSW<12:15>: [3]=A, [2]=M, [1]=W, [0]=P
//   i_sysmask      PSW<0:7>: [7-n] enables channel n (n=0..6), [0] external
//   i_io_req       pending I/O interrupt, bit n = channel n
//   i_ext_req      pending external interrupt
//   i_mck_req      pending machine check
//   i_int_ack      microcode has taken the interrupt (one-cycle pulse)
//   o_wait         wait light
//   o_hold_ros     freeze ROS advance
//   o_int_req      interrupt pending to microcode
//   o_int_class    00 none, 01 machine check, 10 external, 11 I/O
//   o_int_chan     channel number when class=11, else 0
//   o_wait_cnt     cycles spent in the most recent wait
// ---------------------------------------------------------------------------
module x2050wait #(
    parameter logic [5:0] WAIT_SS = 6'd57,
    parameter int         CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ros_advance,
    input  logic [5:0]       i_ss,
    input  logic [3:0]       i_amwp,
    input  logic [7:0]       i_sysmask,
    input  logic [6:0]       i_io_req,
    input  logic             i_ext_req,
    input  logic             i_mck_req,
    input  logic             i_int_ack,
    output logic             o_wait,
    output logic             o_hold_ros,
    output logic             o_int_req,
    output logic [1:0]       o_int_class,
    output logic [2:0]       o_int_chan,
    output logic [CNT_W-1:0] o_wait_cnt
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_MCK  = 2'b01;
    localparam logic [1:0] CLS_EXT  = 2'b10;
    localparam logic [1:0] CLS_IO   = 2'b11;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [1:0]       class_reg, class_next;
    logic [2:0]       chan_reg,  chan_next;

    // A and P bits play no part in wait/interrupt sequencing.
    logic unused_amwp;
    assign unused_amwp = &{1'b0, i_amwp[3], i_amwp[0]};

    // -----------------------------------------------------------------------
    // Request enabling. The system mask is numbered from the PSW MSB, so
    // channel n is enabled by mask bit 7-n.
    // -----------------------------------------------------------------------
    logic [6:0] io_en;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_io_en
            assign io_en[gi] = i_io_req[gi] & i_sysmask[7-gi];
        end
    endgenerate

    logic       mck_en;
    logic       ext_en;
    logic       io_hit;
    logic [2:0] io_chan;

    assign mck_en = i_mck_req & i_amwp[2];
    assign ext_en = i_ext_req & i_sysmask[0];
    assign io_hit = |io_en;

    // Lowest enabled channel wins: scan downward so the last hit is lowest.
    always_comb begin
        io_chan = 3'd0;
        for (int n = 6; n >= 0; n--) begin
            if (io_en[n]) begin
                io_chan = 3'(n);
            end
        end
    end

    logic       any_en;
    logic [1:0] req_class;
    logic [2:0] req_chan;

    always_comb begin
        req_class = CLS_NONE;
        req_chan  = 3'd0;
        if (mck_en) begin
            req_class = CLS_MCK;
        end else if (ext_en) begin
            req_class = CLS_EXT;
        end else if (io_hit) begin
            req_class = CLS_IO;
            req_chan  = io_chan;
        end
    end

    assign any_en = (req_class != CLS_NONE);

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    logic enter_wait;
    assign enter_wait = i_ros_advance & (i_ss == WAIT_SS) & i_amwp[1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        class_next = class_reg;
        chan_next  = chan_reg;

        case (state_reg)
            ST_RUN: begin
                if (enter_wait) begin
                    state_next = ST_WAIT;
                    cnt_next   = '0;
                end
            end

            ST_WAIT: begin
                // Count this WAIT cycle, including the one in which a
                // request is latched; stick at all-ones rather than wrap.
                if (cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
                if (any_en) begin
                    state_next = ST_PEND;
                    class_next = req_class;
                    chan_next  = req_chan;
                end
            end

            ST_PEND: begin
                // Class/chan stay frozen; only an ack leaves PEND. The wait
                // count is kept for inspection until the next wait entry.
                if (i_int_ack) begin
                    state_next = ST_RUN;
                    class_next = CLS_NONE;
                    chan_next  = 3'd0;
                end
            end

            default: begin
                state_next = ST_RUN;
                class_next = CLS_NONE;
                chan_next  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
            class_reg <= CLS_NONE;
            chan_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            class_reg <= class_next;
            chan_reg  <= chan_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded straight from registered state, so reset clears them
    // asynchronously along with the state.
    // -----------------------------------------------------------------------
    assign o_wait      = (state_reg == ST_WAIT) | (state_reg == ST_PEND);
    assign o_hold_ros  = (state_reg == ST_WAIT);
    assign o_int_req   = (state_reg == ST_PEND);
    assign o_int_class = class_reg;
    assign o_int_chan  = chan_reg;
    assign o_wait_cnt  = cnt_reg;

endmodule

// File: tb/tb_x2050wait.sv
// ---------------------------------------------------------------------------
// tb_x2050wait -- self-checking bench for x2050wait.
// A behavioural model tracks the CPU mode (running / waiting / interrupt
// pending) and the wait count; a compare process checks every DUT output
// against it on each falling clock edge. Directed steps add literal checks.
// ---------------------------------------------------------------------------
module tb_x2050wait;

    logic        clk;
    logic        rst;
    logic        ros_advance;
    logic [5:0]  ss;
    logic [3:0]  amwp;
    logic [7:0]  sysmask;
    logic [6:0]  io_req;
    logic        ext_req;
    logic        mck_req;
    logic        int_ack;
    logic        o_wait;
    logic        o_hold_ros;
    logic        o_int_req;
    logic [1:0]  o_int_class;
    logic [2:0]  o_int_chan;
    logic [15:0] o_wait_cnt;

    int errors = 0;
    int checks = 0;

    x2050wait #(.WAIT_SS(6'd57), .CNT_W(16)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_ros_advance (ros_advance),
        .i_ss          (ss),
        .i_amwp        (amwp),
        .i_sysmask     (sysmask),
        .i_io_req      (io_req),
        .i_ext_req     (ext_req),
        .i_mck_req     (mck_req),
        .i_int_ack     (int_ack),
        .o_wait        (o_wait),
        .o_hold_ros    (o_hold_ros),
        .o_int_req     (o_int_req),
        .o_int_class   (o_int_class),
        .o_int_chan    (o_int_chan),
        .o_wait_cnt    (o_wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // mode: 0 = running, 1 = waiting, 2 = interrupt pending
    int m_mode  = 0;
    int m_cnt   = 0;
    int m_class = 0;
    int m_chan  = 0;

    // Returns class*8 + channel for the winning enabled request, 0 if none.
    function automatic int pick(logic [3:0] a, logic [7:0] msk, logic [6:0] io,
                                logic ext, logic mck);
        if (mck && a[2]) return 1 * 8;
        if (ext && msk[0]) return 2 * 8;
        for (int n = 0; n < 7; n++) begin
            if (io[n] && msk[7 - n]) return 3 * 8 + n;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode  <= 0;
            m_cnt   <= 0;
            m_class <= 0;
            m_chan  <= 0;
        end else if (m_mode == 0) begin
            if (ros_advance && ss == 6'd57 && amwp[1]) begin
                m_mode <= 1;
                m_cnt  <= 0;
            end
        end else if (m_mode == 1) begin
            int p;
            p = pick(amwp, sysmask, io_req, ext_req, mck_req);
            m_cnt <= (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (p != 0) begin
                m_mode  <= 2;
                m_class <= p / 8;
                m_chan  <= p % 8;
            end
        end else begin
            if (int_ack) begin
                m_mode  <= 0;
                m_class <= 0;
                m_chan  <= 0;
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        logic [23:0] exp_v, act_v;
        exp_v = {(m_mode != 0), (m_mode == 1), (m_mode == 2),
                 2'(m_class), 3'(m_chan), 16'(m_cnt)};
        act_v = {o_wait, o_hold_ros, o_int_req, o_int_class, o_int_chan, o_wait_cnt};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, act_v, exp_v);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic enter_wait(input logic [3:0] a);
        amwp        = a;
        ss          = 6'd57;
        ros_advance = 1'b1;
        tick();
        ros_advance = 1'b0;
        ss          = 6'd0;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ros_advance = 1'b0; ss = 6'd0; amwp = 4'b0000;
        sysmask = 8'h00; io_req = 7'h00; ext_req = 1'b0; mck_req = 1'b0;
        int_ack = 1'b0;
        tick(3);
        check("reset_wait", {31'd0, o_wait}, 32'd0);
        check("reset_outs", {o_hold_ros, o_int_req, o_int_class, o_int_chan, o_wait_cnt}, 32'd0);
        #2 rst = 1'b0;
        tick();

        // 1. long wait with no requests: count saturates, then async reset
        enter_wait(4'b0010);
        check("t1_hold", {31'd0, o_hold_ros}, 32'd1);
        tick(70000);
        check("t1_cnt_sat", {16'd0, o_wait_cnt}, 32'h0000_FFFF);
        check("t1_wait", {31'd0, o_wait}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t1_async_rst", {o_wait, o_hold_ros, o_int_req, o_int_class, o_int_chan, o_wait_cnt}, 32'd0);
        tick(2);
        #2 rst = 1'b0;
        tick();

        // 2. no entry with W=0, nor without ROS advance
        amwp = 4'b0000; ss = 6'd57; ros_advance = 1'b1;
        tick();
        check("t2_w0_hold", {31'd0, o_hold_ros}, 32'd0);
        amwp = 4'b0010; ros_advance = 1'b0;
        tick();
        check("t2_noadv_hold", {31'd0, o_hold_ros}, 32'd0);
        ss = 6'd56; ros_advance = 1'b1;
        tick();
        check("t2_wrong_ss", {31'd0, o_wait}, 32'd0);
        ros_advance = 1'b0; ss = 6'd0;

        // 3. I/O wake after 5 wait cycles, channels 3 and 5 pending
        enter_wait(4'b0010);
        tick(5);
        check("t3_no_req_yet", {31'd0, o_int_req}, 32'd0);
        io_req = 7'b0101000; sysmask = 8'hFF;
        tick();
        check("t3_req", {31'd0, o_int_req}, 32'd1);
        check("t3_class_chan", {27'd0, o_int_class, o_int_chan}, {27'd0, 2'b11, 3'd3});
        check("t3_cnt", {16'd0, o_wait_cnt}, 32'd6);
        check("t3_hold_rel", {31'd0, o_hold_ros}, 32'd0);
        ack();
        io_req = 7'h00;

        // 4. machine check masked by M=0 -> external wins
        enter_wait(4'b0010);
        mck_req = 1'b1; ext_req = 1'b1; sysmask = 8'h01;
        tick();
        check("t4_ext_class", {30'd0, o_int_class}, 32'd2);
        ack();
        // M=1 with everything already pending at entry -> taken in first cycle
        io_req = 7'h7F; sysmask = 8'hFF;
        enter_wait(4'b0110);
        check("t4_first_wait", {31'd0, o_hold_ros}, 32'd1);
        tick();
        check("t4_mck_class", {27'd0, o_int_class, o_int_chan}, {27'd0, 2'b01, 3'd0});
        check("t4_cnt1", {16'd0, o_wait_cnt}, 32'd1);
        ack();
        mck_req = 1'b0; ext_req = 1'b0;

        // 5. all channels pending but fully masked -> no wake
        io_req = 7'h7F; sysmask = 8'h00;
        enter_wait(4'b0010);
        tick(100);
        check("t5_no_wake", {31'd0, o_int_req}, 32'd0);
        check("t5_cnt100", {16'd0, o_wait_cnt}, 32'd100);
        // enable channel 6 only; an ack in the latching cycle is ignored
        sysmask = 8'h02; int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("t5_chan6", {27'd0, o_int_class, o_int_chan}, {27'd0, 2'b11, 3'd6});
        tick();
        check("t5_ack_ignored", {31'd0, o_int_req}, 32'd1);

        // 6. PEND freezes class/chan; ack returns to RUN, count held
        io_req = 7'h01; sysmask = 8'hFF; mck_req = 1'b1; amwp = 4'b0110; ext_req = 1'b1;
        tick(3);
        check("t6_frozen", {27'd0, o_int_class, o_int_chan}, {27'd0, 2'b11, 3'd6});
        ack();
        check("t6_ack_out", {o_wait, o_int_req, o_int_class, o_int_chan}, 32'd0);
        check("t6_cnt_held", {16'd0, o_wait_cnt}, 32'd101);
        tick(2);
        check("t6_cnt_run", {16'd0, o_wait_cnt}, 32'd101);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
